// File: rtl/ysyx_22041211_pkg.sv
// Shared constants, state encoding and helpers for the instruction fetch unit.
package ysyx_22041211_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC  = 32'h8000_0000;
  localparam logic [1:0]        RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_REQ  = 3'd0,
    ST_WAIT = 3'd1,
    ST_HOLD = 3'd2,
    ST_EXEC = 3'd3,
    ST_ERR  = 3'd4
  } ifu_state_t;

  // True when a read response carries no error.
  function automatic logic resp_ok(input logic [1:0] resp);
    return resp == RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22041211_ifu_if.sv
// Instruction memory read bus: address channel plus read-data channel.
interface ysyx_22041211_ifu_if #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32
);

  logic [ADDR_LEN-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_LEN-1:0] rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ysyx_22041211_Reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_22041211_Reg #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  // Reset wins over write.
  always_ff @(posedge clk) begin
    if (rst)      dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_22041211_ifu.sv
// Single-outstanding instruction fetch unit: request, wait for data, hand the
// instruction downstream, then wait for execution to supply the next pc.
module ysyx_22041211_ifu #(
  parameter int unsigned         ADDR_LEN = 32,
  parameter int unsigned         DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(ysyx_22041211_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22041211_ifu_if.master bus,
  output logic [DATA_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                exu_done,
  input  logic [ADDR_LEN-1:0] next_pc,
  output logic                fetch_err,
  output logic [31:0]         fetch_cnt
);

  import ysyx_22041211_pkg::*;

  ifu_state_t          state;
  logic                arvalid_q;
  logic                rready_q;
  logic                inst_valid_q;
  logic [DATA_LEN-1:0] inst_q;
  logic [31:0]         fetch_cnt_q;
  logic                fetch_err_q;
  logic [ADDR_LEN-1:0] pc;
  logic                pc_we;
  logic                target_aligned;

  assign target_aligned = (next_pc[1:0] == 2'b00);
  assign pc_we          = (state == ST_EXEC) && exu_done && target_aligned;

  // Program counter; only a completed, aligned instruction moves it.
  ysyx_22041211_Reg #(
    .WIDTH     (ADDR_LEN),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .din  (next_pc),
    .wen  (pc_we),
    .dout (pc)
  );

  // Fetch FSM; every handshake output is a flop so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_REQ;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      fetch_cnt_q  <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (arvalid_q && bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_WAIT;
          end else begin
            arvalid_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            if (resp_ok(bus.rresp)) begin
              inst_q       <= bus.rdata;
              inst_valid_q <= 1'b1;
              state        <= ST_HOLD;
            end else begin
              fetch_err_q <= 1'b1;
              state       <= ST_ERR;
            end
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exu_done) begin
            if (target_aligned) begin
              arvalid_q <= 1'b1;
              state     <= ST_REQ;
            end else begin
              fetch_err_q <= 1'b1;
              state       <= ST_ERR;
            end
          end
        end
        ST_ERR: begin
          arvalid_q    <= 1'b0;
          rready_q     <= 1'b0;
          inst_valid_q <= 1'b0;
          fetch_err_q  <= 1'b1;
        end
        default: begin
          arvalid_q    <= 1'b0;
          rready_q     <= 1'b0;
          inst_valid_q <= 1'b0;
          fetch_err_q  <= 1'b1;
          state        <= ST_ERR;
        end
      endcase
    end
  end

  assign bus.araddr  = pc;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign inst        = inst_q;
  assign inst_pc     = pc;
  assign inst_valid  = inst_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for the fetch unit: directed scenarios, then random traffic against a
// transaction-level model of the fetch/issue/execute sequence.
module tb_ysyx_22041211_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        exu_done;
  logic [31:0] next_pc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22041211_ifu_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus_if ();

  ysyx_22041211_ifu #(
    .ADDR_LEN (32),
    .DATA_LEN (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .exu_done   (exu_done),
    .next_pc    (next_pc),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contents of the instruction memory model.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_idle_err(input string tag);
    check({tag, "_arvalid"}, 32'(bus_if.arvalid), 32'd0);
    check({tag, "_rready"}, 32'(bus_if.rready), 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_fetch_err"}, 32'(fetch_err), 32'd1);
  endtask

  // Transaction-level model state for the random phase.
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic [31:0] pend_addr;
  bit          need_fetch, pend, have_inst, exec_busy, ex_now;
  int unsigned dly;

  initial begin
    rst = 1'b1;
    bus_if.arready = 1'b1;
    bus_if.rvalid  = 1'b1;
    bus_if.rdata   = 32'hFFFF_FFFF;
    bus_if.rresp   = 2'b00;
    inst_ready = 1'b1;
    exu_done   = 1'b1;
    next_pc    = 32'h8000_0100;

    // Reset with active-looking inputs: everything must stay quiet.
    repeat (3) tick();
    check("rst_arvalid", 32'(bus_if.arvalid), 32'd0);
    check("rst_rready", 32'(bus_if.rready), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_inst", inst, 32'd0);
    bus_if.rvalid = 1'b0;
    inst_ready = 1'b0;
    exu_done   = 1'b0;

    // First fetch right after reset release.
    rst = 1'b0;
    bus_if.arready = 1'b1;
    tick();
    check("first_arvalid", 32'(bus_if.arvalid), 32'd1);
    check("first_araddr", bus_if.araddr, 32'h8000_0000);
    check("first_rready", 32'(bus_if.rready), 32'd0);
    tick();
    bus_if.arready = 1'b0;
    check("first_acc_arvalid", 32'(bus_if.arvalid), 32'd0);
    check("first_acc_rready", 32'(bus_if.rready), 32'd1);
    bus_if.rvalid = 1'b1;
    bus_if.rdata  = 32'h0010_0093;
    tick();
    bus_if.rvalid = 1'b0;
    check("first_inst_valid", 32'(inst_valid), 32'd1);
    check("first_inst", inst, 32'h0010_0093);
    check("first_inst_pc", inst_pc, 32'h8000_0000);
    check("first_rready_off", 32'(bus_if.rready), 32'd0);

    // Downstream stalls in HOLD.
    bus_if.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_inst", inst, 32'h0010_0093);
      check("hold_inst_pc", inst_pc, 32'h8000_0000);
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_cnt", fetch_cnt, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("accept_cnt", fetch_cnt, 32'd1);
    check("accept_valid", 32'(inst_valid), 32'd0);

    // Branch target, then a stalled request.
    next_pc  = 32'h8000_0010;
    exu_done = 1'b1;
    tick();
    exu_done = 1'b0;
    check("br_arvalid", 32'(bus_if.arvalid), 32'd1);
    check("br_araddr", bus_if.araddr, 32'h8000_0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_arvalid", 32'(bus_if.arvalid), 32'd1);
      check("stall_araddr", bus_if.araddr, 32'h8000_0010);
    end
    bus_if.arready = 1'b1;
    tick();
    bus_if.arready = 1'b0;
    check("stall_acc_arvalid", 32'(bus_if.arvalid), 32'd0);
    tick();
    check("single_hs_arvalid", 32'(bus_if.arvalid), 32'd0);

    // exu_done during WAIT must be ignored.
    next_pc  = 32'h8000_0040;
    exu_done = 1'b1;
    tick();
    exu_done = 1'b0;
    check("wait_exu_rready", 32'(bus_if.rready), 32'd1);
    check("wait_exu_arvalid", 32'(bus_if.arvalid), 32'd0);
    bus_if.rvalid = 1'b1;
    bus_if.rdata  = 32'h0020_8113;
    tick();
    bus_if.rvalid = 1'b0;
    check("second_inst_valid", 32'(inst_valid), 32'd1);
    check("second_inst", inst, 32'h0020_8113);
    check("second_inst_pc", inst_pc, 32'h8000_0010);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("second_cnt", fetch_cnt, 32'd2);

    // Misaligned target goes to the sticky error state.
    next_pc  = 32'h8000_0002;
    exu_done = 1'b1;
    tick();
    exu_done = 1'b0;
    check_idle_err("misalign");
    bus_if.arready = 1'b1;
    bus_if.rvalid  = 1'b1;
    inst_ready = 1'b1;
    exu_done   = 1'b1;
    next_pc    = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle_err("misalign_hold");
    end
    bus_if.arready = 1'b0;
    bus_if.rvalid  = 1'b0;
    inst_ready = 1'b0;
    exu_done   = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    check("err_rst_clear", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    tick();
    check("err_rst_arvalid", 32'(bus_if.arvalid), 32'd1);
    check("err_rst_araddr", bus_if.araddr, 32'h8000_0000);
    check("err_rst_cnt", fetch_cnt, 32'd0);

    // Error response.
    bus_if.arready = 1'b1;
    tick();
    bus_if.arready = 1'b0;
    bus_if.rvalid = 1'b1;
    bus_if.rresp  = 2'b10;
    tick();
    bus_if.rvalid = 1'b0;
    bus_if.rresp  = 2'b00;
    check_idle_err("rresp");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_err("rresp_hold");
    end

    // Reset in the middle of WAIT abandons the fetch.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus_if.arready = 1'b1;
    tick();
    bus_if.arready = 1'b0;
    check("midwait_rready", 32'(bus_if.rready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midwait_arvalid", 32'(bus_if.arvalid), 32'd1);
    check("midwait_araddr", bus_if.araddr, 32'h8000_0000);
    check("midwait_cnt", fetch_cnt, 32'd0);
    check("midwait_rready_off", 32'(bus_if.rready), 32'd0);

    // Random traffic.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_pc     = 32'h8000_0000;
    exp_cnt    = 32'd0;
    pend_addr  = 32'd0;
    need_fetch = 1'b1;
    pend       = 1'b0;
    have_inst  = 1'b0;
    exec_busy  = 1'b0;
    dly        = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rand_arvalid", 32'(bus_if.arvalid), 32'(need_fetch));
      check("rand_rready", 32'(bus_if.rready), 32'(pend));
      check("rand_inst_valid", 32'(inst_valid), 32'(have_inst));
      if (bus_if.arvalid) check("rand_araddr", bus_if.araddr, exp_pc);
      if (inst_valid) begin
        check("rand_inst", inst, memf(exp_pc));
        check("rand_inst_pc", inst_pc, exp_pc);
      end
      check("rand_cnt", fetch_cnt, exp_cnt);
      check("rand_err", 32'(fetch_err), 32'd0);

      bus_if.arready = ($urandom_range(0, 2) != 0);
      if (pend && dly == 0) begin
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = memf(pend_addr);
        bus_if.rresp  = 2'b00;
      end else if (!pend && $urandom_range(0, 3) == 0) begin
        bus_if.rvalid = 1'b1;
        bus_if.rdata  = $urandom;
        bus_if.rresp  = 2'($urandom_range(0, 3));
      end else begin
        bus_if.rvalid = 1'b0;
        bus_if.rdata  = $urandom;
        bus_if.rresp  = 2'b00;
      end
      inst_ready = ($urandom_range(0, 1) != 0);
      exu_done   = ($urandom_range(0, 2) == 0);
      next_pc    = 32'h8000_0000 | (32'($urandom) & 32'h0000_FFFC);

      ex_now = exec_busy;
      if (pend && bus_if.rvalid && bus_if.rready) begin
        pend      = 1'b0;
        have_inst = 1'b1;
      end else if (pend && dly > 0) begin
        dly--;
      end
      if (bus_if.arvalid && bus_if.arready) begin
        pend       = 1'b1;
        pend_addr  = exp_pc;
        dly        = $urandom_range(0, 3);
        need_fetch = 1'b0;
      end
      if (inst_valid && inst_ready) begin
        exp_cnt   = exp_cnt + 32'd1;
        have_inst = 1'b0;
        exec_busy = 1'b1;
      end
      if (exu_done && ex_now) begin
        exp_pc     = next_pc;
        exec_busy  = 1'b0;
        need_fetch = 1'b1;
      end
      tick();
    end
    check("rand_progress", 32'(exp_cnt > 32'd100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_ifu.md
YSYX_22041211_IFU -- requirements
Module: ysyx_22041211_IFU

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, meaning instruction/data width.
REQ-003 SHALL have parameter RESET_PC, default 32'h80000000, meaning first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port araddr  output  ADDR_LEN  fetch address to instruction memory.
REQ-007 SHALL have port arvalid  output  1  fetch request valid.
REQ-008 SHALL have port arready  input  1  memory accepts request.
REQ-009 SHALL have port rdata  input  DATA_LEN  returned instruction word.
REQ-010 SHALL have port rresp  input  2  response code; 2'b00 means OKAY, any other value means error.
REQ-011 SHALL have port rvalid  input  1  read data valid.
REQ-012 SHALL have port rready  output  1  IFU accepts read data.
REQ-013 SHALL have port inst  output  DATA_LEN  instruction to decode/execute.
REQ-014 SHALL have port inst_pc  output  ADDR_LEN  PC of inst.
REQ-015 SHALL have port inst_valid  output  1  inst/inst_pc valid.
REQ-016 SHALL have port inst_ready  input  1  downstream accepts inst.
REQ-017 SHALL have port exu_done  input  1  downstream finished the current instruction; next_pc is valid.
REQ-018 SHALL have port next_pc  input  ADDR_LEN  PC of the next instruction (pcPlus, branch or jalr target).
REQ-019 SHALL have port fetch_err  output  1  sticky fault flag.
REQ-020 SHALL have port fetch_cnt  output  32  count of instructions handed downstream.

Function
REQ-021 SHALL implement a 5-state FSM with states REQ, WAIT, HOLD, EXEC and ERR.
REQ-022 In REQ, the IFU SHALL drive arvalid=1 and araddr=pc; on arready=1 it SHALL move to WAIT.
REQ-023 araddr SHALL remain stable while arvalid=1 and arready=0.
REQ-024 In WAIT, the IFU SHALL drive rready=1; on rvalid=1 with rresp=00 it SHALL latch rdata into inst and move to HOLD.
REQ-025 In WAIT, on rvalid=1 with rresp!=00 the IFU SHALL set fetch_err=1 and move to ERR.
REQ-026 An rvalid asserted outside WAIT SHALL be ignored, with rready=0.
REQ-027 In HOLD, the IFU SHALL drive inst_valid=1 with inst and inst_pc held stable; on inst_ready=1 it SHALL increment fetch_cnt (wrapping 0xFFFFFFFF->0) and move to EXEC.
REQ-028 In EXEC, on exu_done=1 with next_pc[1:0]==00 the IFU SHALL load pc<=next_pc and move to REQ.
REQ-029 In EXEC, on exu_done=1 with next_pc[1:0]!=00 the IFU SHALL set fetch_err=1 and move to ERR (misaligned target).
REQ-030 exu_done SHALL be ignored in every state except EXEC.
REQ-031 In ERR, the IFU SHALL hold arvalid, rready and inst_valid at 0, with fetch_err=1, until rst.
REQ-032 arvalid, rready and inst_valid SHALL be registered/state-decoded outputs with no combinational path from any input.
REQ-033 Minimum request-to-issue latency SHALL be: REQ accept -> rvalid at earliest the next cycle -> inst_valid the cycle after rvalid.
REQ-034 At most one fetch SHALL be outstanding; no speculative or next-line fetch.

Reset
REQ-035 While rst=1 at a clock edge, the IFU SHALL set state=REQ, pc=RESET_PC, inst=0, fetch_cnt=0 and fetch_err=0.
REQ-036 While rst=1, outputs SHALL be arvalid=0, rready=0 and inst_valid=0.
REQ-037 In the first cycle after rst falls, the IFU SHALL drive arvalid=1 and araddr=RESET_PC.
REQ-038 Reset asserted mid-transaction (WAIT, HOLD or EXEC) SHALL abandon the transaction; the memory model shares rst and SHALL drop its pending response.

Structure
REQ-039 State encodings, RESP_OKAY=2'b00 and RESET_PC SHALL be defined in shared package ysyx_22041211_pkg.
REQ-040 The pc register SHALL be one instance of sub-module ysyx_22041211_Reg (width, reset value, write enable); the FSM, inst latch and counter SHALL be inline.

Verification
REQ-041 Release rst; arready=1 in the first cycle; rdata=0x00100093, rvalid one cycle later -> araddr=0x80000000, then inst_valid=1, inst=0x00100093, inst_pc=0x80000000.
REQ-042 Hold arready=0 for 3 cycles -> arvalid=1 and araddr stable all 3 cycles; exactly one handshake.
REQ-043 Hold inst_ready=0 for 4 cycles in HOLD -> inst/inst_pc unchanged; fetch_cnt increments by exactly 1 on acceptance.
REQ-044 exu_done=1 with next_pc=0x80000010 -> next araddr=0x80000010; exu_done pulsed during WAIT -> no effect.
REQ-045 rresp=2'b10, or next_pc=0x80000002 -> fetch_err=1 and all valids 0 forever; a subsequent rst -> fetch restarts at 0x80000000.
REQ-046 Assert rst while in WAIT -> the cycle after release arvalid=1, araddr=0x80000000, fetch_cnt=0.
